eth_hdr_extract: RTL and testbench

Avalon-ST sink that sits directly downstream of the 64-bit pcap replay source (or a real 10G MAC RX) and parses each frame's Ethernet, IPv4 and UDP header fields on the fly. Once per frame, at end-of-packet, it presents a registered header record with a valid/ready handshake, together with frame length and error flags. It feeds test-bench scoreboards and downstream flow classifiers. It is synthesizable, with no file I/O.

---
 rtl/eth_hdr_extract.sv | 243 ++++++++++++++++++++++++
 tb/tb_eth_hdr_extract.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_hdr_extract.sv
// Ethernet/IPv4/UDP header extractor: one registered record per frame, valid the cycle after the eop beat.
// Backpressure: input stalls only while a finished record waits unconsumed (one-deep record buffer).
module eth_hdr_extract #(
  parameter int CNT_W = 16
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic [63:0]       asi_in_data,
  input  logic              asi_in_valid,
  output logic              asi_in_ready,
  input  logic              asi_in_sop,
  input  logic              asi_in_eop,
  input  logic [2:0]        asi_in_empty,
  input  logic [5:0]        asi_in_error,
  output logic              hdr_valid,
  input  logic              hdr_ready,
  output logic [47:0]       hdr_dst_mac,
  output logic [47:0]       hdr_src_mac,
  output logic [15:0]       hdr_ethertype,
  output logic [7:0]        hdr_ip_proto,
  output logic [31:0]       hdr_ip_src,
  output logic [31:0]       hdr_ip_dst,
  output logic [15:0]       hdr_udp_sport,
  output logic [15:0]       hdr_udp_dport,
  output logic [15:0]       hdr_len,
  output logic              hdr_is_ipv4,
  output logic              hdr_is_udp,
  output logic              hdr_err,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  drop_count
);

  typedef enum logic {IDLE, IN_PKT} state_t;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic [3:0]  ihl;
    logic [7:0]  ip_proto;
    logic [31:0] ip_src;
    logic [31:0] ip_dst;
    logic [15:0] udp_sport;
    logic [15:0] udp_dport;
  } cap_t;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic [7:0]  ip_proto;
    logic [31:0] ip_src;
    logic [31:0] ip_dst;
    logic [15:0] udp_sport;
    logic [15:0] udp_dport;
    logic [15:0] len;
    logic        is_ipv4;
    logic        is_udp;
    logic        err;
  } hdr_t;

  localparam logic [63:0]      ALL_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  // Accumulator stops one beat past 64 KiB so a later subtraction of empty still clamps.
  localparam logic [16:0]      LEN_HOLD = 17'h10008;

  state_t      state_q, state_nxt;
  logic [2:0]  beat_idx_q, beat_idx_nxt;
  cap_t        cap_q, cap_nxt;
  logic [16:0] len_acc_q, len_acc_nxt;
  logic        err_acc_q, err_acc_nxt;
  hdr_t        rec_q, rec_nxt;
  logic        hdr_valid_q, hdr_valid_nxt;
  logic [CNT_W-1:0] pkt_q, drop_q;
  logic        pkt_inc, drop_inc;

  logic        beat_acc;
  logic [63:0] lane_mask;
  logic [63:0] data_m;
  logic [2:0]  cur_idx;
  logic [16:0] len_base;
  logic [16:0] len_sum;
  logic [15:0] fin_len;
  logic        err_base;
  logic        is_v4;
  logic        is_udp;

  assign asi_in_ready = !(hdr_valid_q && !hdr_ready);
  assign beat_acc     = asi_in_valid && asi_in_ready;

  // Empty lanes on the eop beat were never received, so they must not leak into fields.
  assign lane_mask = asi_in_eop ? (ALL_ONES << {asi_in_empty, 3'b000}) : ALL_ONES;
  assign data_m    = asi_in_data & lane_mask;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state_q;
    beat_idx_nxt  = beat_idx_q;
    cap_nxt       = cap_q;
    len_acc_nxt   = len_acc_q;
    err_acc_nxt   = err_acc_q;
    rec_nxt       = rec_q;
    hdr_valid_nxt = hdr_valid_q && !hdr_ready;
    pkt_inc       = 1'b0;
    drop_inc      = 1'b0;
    cur_idx       = beat_idx_q;
    len_base      = len_acc_q;
    err_base      = err_acc_q;
    len_sum       = '0;
    fin_len       = '0;
    is_v4         = 1'b0;
    is_udp        = 1'b0;

    if (beat_acc) begin
      if (state_q == IDLE && !asi_in_sop) begin
        drop_inc = 1'b1;
      end else begin
        if (asi_in_sop) begin
          // A sop inside a frame abandons the unfinished one.
          drop_inc = (state_q == IN_PKT);
          cur_idx  = 3'd0;
          cap_nxt  = '0;
          len_base = '0;
          err_base = 1'b0;
        end

        case (cur_idx)
          3'd0: begin
            cap_nxt.dst_mac        = data_m[63:16];
            cap_nxt.src_mac[47:32] = data_m[15:0];
          end
          3'd1: begin
            cap_nxt.src_mac[31:0] = data_m[63:32];
            cap_nxt.ethertype     = data_m[31:16];
            cap_nxt.ihl           = data_m[11:8];
          end
          3'd2: begin
            cap_nxt.ip_proto = data_m[7:0];
          end
          3'd3: begin
            cap_nxt.ip_src        = data_m[47:16];
            cap_nxt.ip_dst[31:16] = data_m[15:0];
          end
          3'd4: begin
            cap_nxt.ip_dst[15:0] = data_m[63:48];
            cap_nxt.udp_sport    = data_m[47:32];
            cap_nxt.udp_dport    = data_m[31:16];
          end
          default: begin
          end
        endcase

        beat_idx_nxt = (cur_idx < 3'd5) ? cur_idx + 3'd1 : 3'd5;
        len_acc_nxt  = (len_base >= LEN_HOLD) ? len_base : len_base + 17'd8;
        err_acc_nxt  = err_base | (|asi_in_error);
        state_nxt    = IN_PKT;

        if (asi_in_eop) begin
          len_sum = len_acc_nxt - {14'd0, asi_in_empty};
          fin_len = len_sum[16] ? 16'hFFFF : len_sum[15:0];
          is_v4   = (cap_nxt.ethertype == 16'h0800) && (cap_nxt.ihl >= 4'd5) &&
                    (fin_len >= 16'd34);
          is_udp  = is_v4 && (cap_nxt.ip_proto == 8'd17) && (cap_nxt.ihl == 4'd5) &&
                    (fin_len >= 16'd38);

          rec_nxt.dst_mac   = cap_nxt.dst_mac;
          rec_nxt.src_mac   = cap_nxt.src_mac;
          rec_nxt.ethertype = cap_nxt.ethertype;
          rec_nxt.ip_proto  = cap_nxt.ip_proto;
          rec_nxt.ip_src    = cap_nxt.ip_src;
          rec_nxt.ip_dst    = cap_nxt.ip_dst;
          rec_nxt.udp_sport = cap_nxt.udp_sport;
          rec_nxt.udp_dport = cap_nxt.udp_dport;
          rec_nxt.len       = fin_len;
          rec_nxt.is_ipv4   = is_v4;
          rec_nxt.is_udp    = is_udp;
          rec_nxt.err       = err_acc_nxt || (fin_len < 16'd14);

          hdr_valid_nxt = 1'b1;
          pkt_inc       = 1'b1;
          state_nxt     = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      beat_idx_q  <= '0;
      cap_q       <= '0;
      len_acc_q   <= '0;
      err_acc_q   <= 1'b0;
      rec_q       <= '0;
      hdr_valid_q <= 1'b0;
    end else begin
      beat_idx_q  <= beat_idx_nxt;
      cap_q       <= cap_nxt;
      len_acc_q   <= len_acc_nxt;
      err_acc_q   <= err_acc_nxt;
      rec_q       <= rec_nxt;
      hdr_valid_q <= hdr_valid_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      pkt_q  <= '0;
      drop_q <= '0;
    end else begin
      if (pkt_inc && pkt_q != CNT_MAX) begin
        pkt_q <= pkt_q + CNT_ONE;
      end
      if (drop_inc && drop_q != CNT_MAX) begin
        drop_q <= drop_q + CNT_ONE;
      end
    end
  end

  assign hdr_valid     = hdr_valid_q;
  assign hdr_dst_mac   = rec_q.dst_mac;
  assign hdr_src_mac   = rec_q.src_mac;
  assign hdr_ethertype = rec_q.ethertype;
  assign hdr_ip_proto  = rec_q.ip_proto;
  assign hdr_ip_src    = rec_q.ip_src;
  assign hdr_ip_dst    = rec_q.ip_dst;
  assign hdr_udp_sport = rec_q.udp_sport;
  assign hdr_udp_dport = rec_q.udp_dport;
  assign hdr_len       = rec_q.len;
  assign hdr_is_ipv4   = rec_q.is_ipv4;
  assign hdr_is_udp    = rec_q.is_udp;
  assign hdr_err       = rec_q.err;
  assign pkt_count     = pkt_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_eth_hdr_extract.sv
// Directed bench for eth_hdr_extract: frames built byte-wise, records checked against hand-computed values.
module tb_eth_hdr_extract;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic [63:0] asi_in_data;
  logic        asi_in_valid;
  logic        asi_in_ready;
  logic        asi_in_sop;
  logic        asi_in_eop;
  logic [2:0]  asi_in_empty;
  logic [5:0]  asi_in_error;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [47:0] hdr_dst_mac;
  logic [47:0] hdr_src_mac;
  logic [15:0] hdr_ethertype;
  logic [7:0]  hdr_ip_proto;
  logic [31:0] hdr_ip_src;
  logic [31:0] hdr_ip_dst;
  logic [15:0] hdr_udp_sport;
  logic [15:0] hdr_udp_dport;
  logic [15:0] hdr_len;
  logic        hdr_is_ipv4;
  logic        hdr_is_udp;
  logic        hdr_err;
  logic [15:0] pkt_count;
  logic [15:0] drop_count;

  always #5 clk_in = ~clk_in;

  eth_hdr_extract #(.CNT_W(16)) dut (
    .clk_in(clk_in), .reset_n(reset_n),
    .asi_in_data(asi_in_data), .asi_in_valid(asi_in_valid), .asi_in_ready(asi_in_ready),
    .asi_in_sop(asi_in_sop), .asi_in_eop(asi_in_eop), .asi_in_empty(asi_in_empty),
    .asi_in_error(asi_in_error),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .hdr_dst_mac(hdr_dst_mac), .hdr_src_mac(hdr_src_mac), .hdr_ethertype(hdr_ethertype),
    .hdr_ip_proto(hdr_ip_proto), .hdr_ip_src(hdr_ip_src), .hdr_ip_dst(hdr_ip_dst),
    .hdr_udp_sport(hdr_udp_sport), .hdr_udp_dport(hdr_udp_dport), .hdr_len(hdr_len),
    .hdr_is_ipv4(hdr_is_ipv4), .hdr_is_udp(hdr_is_udp), .hdr_err(hdr_err),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  typedef struct packed {
    logic [15:0] ethertype;
    logic [31:0] ip_src;
    logic [15:0] len;
  } rec_t;

  rec_t rec_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [7:0] fb [0:127];

  always @(posedge clk_in) begin
    if (reset_n && hdr_valid && hdr_ready) begin
      rec_q.push_back({hdr_ethertype, hdr_ip_src, hdr_len});
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic put(input int off, input logic [63:0] val, input int nbytes);
    for (int j = 0; j < nbytes; j++) fb[off+j] = val[8*(nbytes-1-j) +: 8];
  endtask

  task automatic build_udp();
    for (int i = 0; i < 128; i++) fb[i] = i[7:0];
    put(0,  64'h0011_2233_4455, 6);
    put(6,  64'h6677_8899_aabb, 6);
    put(12, 64'h0800, 2);
    put(14, 64'h45, 1);
    put(23, 64'h11, 1);
    put(26, 64'h0a00_0001, 4);
    put(30, 64'h0a00_0002, 4);
    put(34, 64'h04d2, 2);
    put(36, 64'h162e, 2);
  endtask

  task automatic build_arp();
    for (int i = 0; i < 128; i++) fb[i] = i[7:0];
    put(0,  64'hffff_ffff_ffff, 6);
    put(6,  64'h6677_8899_aabb, 6);
    put(12, 64'h0806, 2);
    put(14, 64'h0001, 2);
  endtask

  task automatic send_beat(input logic [63:0] d, input logic sop, input logic eop,
                           input logic [2:0] emp, input logic [5:0] err);
    logic acc;
    acc = 1'b0;
    @(negedge clk_in);
    asi_in_valid = 1'b1;
    asi_in_data  = d;
    asi_in_sop   = sop;
    asi_in_eop   = eop;
    asi_in_empty = emp;
    asi_in_error = err;
    for (int n = 0; n < 200 && !acc; n++) begin
      #4;
      acc = asi_in_ready;
      @(posedge clk_in);
      if (!acc) @(negedge clk_in);
    end
    if (!acc) chk("beat_accept_timeout", {63'd0, acc}, 64'd1);
  endtask

  task automatic send_frame(input int len, input int err_beat, input logic [5:0] ev,
                            input int max_beats);
    int nb, emp, sent;
    logic [63:0] d;
    nb   = (len + 7) / 8;
    emp  = nb * 8 - len;
    sent = (max_beats < nb) ? max_beats : nb;
    for (int b = 0; b < sent; b++) begin
      for (int j = 0; j < 8; j++) d[63-8*j -: 8] = fb[8*b+j];
      send_beat(d, b == 0, b == nb - 1, (b == nb - 1) ? emp[2:0] : 3'd0,
                (b == err_beat) ? ev : 6'd0);
    end
    #1 asi_in_valid = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    asi_in_valid = 1'b0;
    asi_in_data  = '0;
    asi_in_sop   = 1'b0;
    asi_in_eop   = 1'b0;
    asi_in_empty = '0;
    asi_in_error = '0;
    hdr_ready    = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_hdr_valid", hdr_valid, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_hdr_len", hdr_len, 0);
    chk("rst_dst_mac", hdr_dst_mac, 0);
    reset_n = 1'b1;
    @(negedge clk_in);
    #1 chk("rst_in_ready", asi_in_ready, 1);

    // 60-byte UDP frame
    hdr_ready = 1'b1;
    build_udp();
    send_frame(60, -1, 6'd0, 99);
    chk("udp_valid_latency", hdr_valid, 1);
    chk("udp_len", hdr_len, 60);
    chk("udp_is_ipv4", hdr_is_ipv4, 1);
    chk("udp_is_udp", hdr_is_udp, 1);
    chk("udp_ip_src", hdr_ip_src, 32'h0a00_0001);
    chk("udp_ip_dst", hdr_ip_dst, 32'h0a00_0002);
    chk("udp_sport", hdr_udp_sport, 16'h04d2);
    chk("udp_dport", hdr_udp_dport, 16'h162e);
    chk("udp_proto", hdr_ip_proto, 8'h11);
    chk("udp_dst_mac", hdr_dst_mac, 48'h0011_2233_4455);
    chk("udp_src_mac", hdr_src_mac, 48'h6677_8899_aabb);
    chk("udp_err", hdr_err, 0);
    chk("udp_pkt_count", pkt_count, 1);
    repeat (2) @(negedge clk_in);

    // 42-byte ARP frame
    build_arp();
    send_frame(42, -1, 6'd0, 99);
    chk("arp_ethertype", hdr_ethertype, 16'h0806);
    chk("arp_len", hdr_len, 42);
    chk("arp_is_ipv4", hdr_is_ipv4, 0);
    chk("arp_is_udp", hdr_is_udp, 0);
    chk("arp_pkt_count", pkt_count, 2);
    repeat (2) @(negedge clk_in);

    // Consumer stalled across two frames
    rec_q.delete();
    hdr_ready = 1'b0;
    build_udp();
    send_frame(60, -1, 6'd0, 99);
    chk("bp_valid", hdr_valid, 1);
    chk("bp_in_ready_drop", asi_in_ready, 0);
    build_arp();
    fork
      send_frame(42, -1, 6'd0, 99);
      begin
        repeat (4) @(negedge clk_in);
        #1;
        chk("bp_stall_valid", hdr_valid, 1);
        chk("bp_stall_ip_src", hdr_ip_src, 32'h0a00_0001);
        chk("bp_stall_len", hdr_len, 60);
        chk("bp_stall_in_ready", asi_in_ready, 0);
        hdr_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk_in);
    chk("bp_rec_count", rec_q.size(), 2);
    if (rec_q.size() == 2) begin
      chk("bp_rec0_ip_src", rec_q[0].ip_src, 32'h0a00_0001);
      chk("bp_rec0_len", rec_q[0].len, 60);
      chk("bp_rec1_ethertype", rec_q[1].ethertype, 16'h0806);
      chk("bp_rec1_len", rec_q[1].len, 42);
    end
    chk("bp_pkt_count", pkt_count, 4);

    // Errored and runt frames
    build_udp();
    send_frame(60, 3, 6'h01, 99);
    chk("errbeat_err", hdr_err, 1);
    chk("errbeat_len", hdr_len, 60);
    chk("errbeat_pkt_count", pkt_count, 5);
    repeat (2) @(negedge clk_in);
    send_frame(10, -1, 6'd0, 99);
    chk("runt10_len", hdr_len, 10);
    chk("runt10_err", hdr_err, 1);
    chk("runt10_is_ipv4", hdr_is_ipv4, 0);
    repeat (2) @(negedge clk_in);
    send_frame(2, -1, 6'd0, 99);
    chk("runt2_len", hdr_len, 2);
    chk("runt2_err", hdr_err, 1);
    chk("runt2_dst_mac_masked", hdr_dst_mac, 48'h0011_0000_0000);
    chk("runt2_ethertype_zero", hdr_ethertype, 0);
    chk("runt2_pkt_count", pkt_count, 7);
    repeat (2) @(negedge clk_in);

    // Truncated frame then orphan beat
    rec_q.delete();
    build_udp();
    send_frame(60, -1, 6'd0, 2);
    build_arp();
    send_frame(42, -1, 6'd0, 99);
    chk("trunc_drop_count", drop_count, 1);
    chk("trunc_ethertype", hdr_ethertype, 16'h0806);
    chk("trunc_len", hdr_len, 42);
    chk("trunc_pkt_count", pkt_count, 8);
    repeat (2) @(negedge clk_in);
    chk("trunc_rec_count", rec_q.size(), 1);
    send_beat(64'hdead_beef_0000_0001, 1'b0, 1'b0, 3'd0, 6'd0);
    #1 asi_in_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("orphan_drop_count", drop_count, 2);
    chk("orphan_pkt_count", pkt_count, 8);
    chk("orphan_no_record", hdr_valid, 0);

    // Reset mid-frame
    build_udp();
    send_frame(60, -1, 6'd0, 3);
    @(negedge clk_in);
    reset_n = 1'b0;
    #1;
    chk("midrst_hdr_valid", hdr_valid, 0);
    chk("midrst_pkt_count", pkt_count, 0);
    chk("midrst_drop_count", drop_count, 0);
    chk("midrst_len", hdr_len, 0);
    chk("midrst_ip_src", hdr_ip_src, 0);
    chk("midrst_ethertype", hdr_ethertype, 0);
    @(negedge clk_in);
    reset_n = 1'b1;
    send_beat(64'h0123_4567_89ab_cdef, 1'b0, 1'b0, 3'd0, 6'd0);
    #1 asi_in_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("postrst_orphan_drop", drop_count, 1);
    send_frame(60, -1, 6'd0, 99);
    chk("postrst_pkt_count", pkt_count, 1);
    chk("postrst_is_udp", hdr_is_udp, 1);
    chk("postrst_len", hdr_len, 60);
    chk("postrst_sport", hdr_udp_sport, 16'h04d2);
    repeat (3) @(negedge clk_in);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
